// File: rtl/cpu_types_pkg.sv
// Shared types for the pending-request unit: head FSM states and the queue entry layout.
package cpu_types_pkg;

  // The entry carries the widest supported address/data; instances narrower than this zero-extend on capture.
  localparam int PKG_ADDR_W = 32;
  localparam int PKG_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } head_state_t;

  typedef struct packed {
    logic                  write;
    logic [PKG_ADDR_W-1:0] addr;
    logic [PKG_DATA_W-1:0] data;
  } req_entry_t;

endpackage

// File: rtl/req_fifo.sv
// Circular queue of pending data requests; the head entry is visible combinationally on dout.
module req_fifo
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  req_entry_t               din,
  output req_entry_t               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  req_entry_t    mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  // DEPTH is a power of two, so pointer wrap is the natural binary rollover.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  assign dout  = mem[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/pend_req_unit.sv
// Pending load/store request queue with a head FSM that retries stalled requests and drops them after MAX_RETRY.
module pend_req_unit
  import cpu_types_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 16,
  parameter int MAX_RETRY = 2
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   ihit,
  input  logic                   dhit,
  input  logic                   dmemREN,
  input  logic                   dmemWEN,
  input  logic [ADDR_W-1:0]      dmemaddr,
  input  logic [DATA_W-1:0]      dmemstore,
  input  logic                   halt,
  output logic                   iREN,
  output logic                   dREN,
  output logic                   dWEN,
  output logic [ADDR_W-1:0]      daddr,
  output logic [DATA_W-1:0]      dstore,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   drained,
  output logic                   timeout_err,
  output logic                   overflow,
  output logic [1:0]             head_state
);

  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int WAIT_W  = $clog2(TIMEOUT) + 1;
  localparam int RETRY_W = $clog2(MAX_RETRY + 1) + 1;

  head_state_t        state, state_nxt;
  logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
  logic [RETRY_W-1:0] retry_cnt, retry_nxt;
  logic               halt_seen;
  logic               enq, push, pop, drop;
  req_entry_t         new_entry, head;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full, fifo_empty;

  assign enq = ihit && (dmemREN || dmemWEN);

  always_comb begin
    new_entry       = '0;
    new_entry.write = dmemWEN;
    new_entry.addr  = PKG_ADDR_W'(dmemaddr);
    new_entry.data  = PKG_DATA_W'(dmemstore);
  end

  req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (CLK),
    .rst_n (nRST),
    .push  (push),
    .pop   (pop),
    .din   (new_entry),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    retry_nxt = retry_cnt;
    pop       = 1'b0;
    drop      = 1'b0;
    case (state)
      REQ: begin
        if (dhit && !fifo_empty) begin
          pop       = 1'b1;
          wait_nxt  = '0;
          retry_nxt = '0;
        end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
          state_nxt = GAP;
          wait_nxt  = '0;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      GAP: begin
        if (retry_cnt == RETRY_W'(MAX_RETRY)) begin
          pop       = 1'b1;
          drop      = 1'b1;
          wait_nxt  = '0;
          retry_nxt = '0;
        end else begin
          retry_nxt = retry_cnt + RETRY_W'(1);
          state_nxt = REQ;
        end
      end
      default: ;
    endcase
    // A same-edge pop frees the slot, so a full queue still accepts the new entry.
    push = enq && (!fifo_full || pop);
    if (pop)
      state_nxt = (fifo_count > CW'(1) || push) ? REQ : IDLE;
    else if (state == IDLE && (push || !fifo_empty))
      state_nxt = REQ;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      retry_cnt   <= '0;
      halt_seen   <= 1'b0;
      timeout_err <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_nxt;
      retry_cnt   <= retry_nxt;
      halt_seen   <= halt_seen || halt;
      timeout_err <= timeout_err || drop;
      overflow    <= overflow || (enq && !push);
    end
  end

  // Handshake: the head request is valid while dREN|dWEN is high and completes on the rising edge where dhit is also high.
  assign dREN       = (state == REQ) && !fifo_empty && !head.write;
  assign dWEN       = (state == REQ) && !fifo_empty && head.write;
  assign daddr      = ADDR_W'(head.addr);
  assign dstore     = DATA_W'(head.data);
  assign iREN       = !((fifo_full && !dhit) || halt_seen || halt);
  assign count      = fifo_count;
  assign full       = fifo_full;
  assign empty      = fifo_empty;
  assign drained    = halt_seen && fifo_empty;
  assign head_state = state;

endmodule

// File: tb/tb_pend_req_unit.sv
// Directed bench for pend_req_unit: completed requests are scoreboarded, status outputs checked against hand-derived values.
module tb_pend_req_unit;
  import cpu_types_pkg::*;

  localparam int DEPTH     = 4;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int TIMEOUT   = 4;
  localparam int MAX_RETRY = 2;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              ihit, dhit, dmemREN, dmemWEN, halt;
  logic [ADDR_W-1:0] dmemaddr;
  logic [DATA_W-1:0] dmemstore;
  logic              iREN, dREN, dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic [2:0]        count;
  logic              full, empty, drained, timeout_err, overflow;
  logic [1:0]        head_state;

  logic [64:0] exp_q[$];
  logic [64:0] mon_obs;
  logic [64:0] mon_exp;
  logic [15:0] pat;
  int checks = 0;
  int passed = 0;

  pend_req_unit #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .halt(halt), .iREN(iREN), .dREN(dREN),
    .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .count(count),
    .full(full), .empty(empty), .drained(drained),
    .timeout_err(timeout_err), .overflow(overflow), .head_state(head_state)
  );

  // Clock and watchdog
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Scoreboard monitor: a request completes when it is presented and dhit is high.
  always @(negedge CLK) begin
    if (nRST && (dREN || dWEN) && dhit) begin
      mon_obs = {dWEN, daddr, dstore};
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL sb_unexpected: got %0h required no completion", mon_obs);
      end else begin
        mon_exp = exp_q.pop_front();
        check("sb_txn", mon_obs, mon_exp);
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic enq(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic hit);
    ihit      = 1'b1;
    dmemREN   = !wr;
    dmemWEN   = wr;
    dmemaddr  = a;
    dmemstore = d;
    dhit      = hit;
    tick();
    ihit    = 1'b0;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
    dhit    = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b0; dhit = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
    halt = 1'b0; dmemaddr = '0; dmemstore = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_dren", dREN, 0);
    check("rst_dwen", dWEN, 0);
    check("rst_iren", iREN, 1);
    check("rst_empty", empty, 1);
    check("rst_count", count, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_ovf", overflow, 0);
    nRST = 1'b1;
    tick();

    // Reset mid-request: queued load vanishes as soon as nRST falls
    enq(1'b0, 32'h80, 32'h0, 1'b0);
    check("mid_dren_pre", dREN, 1);
    tick();
    #2 nRST = 1'b0;
    #1;
    check("mid_dren", dREN, 0);
    check("mid_dwen", dWEN, 0);
    check("mid_count", count, 0);
    check("mid_iren", iREN, 1);
    check("mid_empty", empty, 1);
    nRST = 1'b1;
    tick();

    // Single load, completed two cycles after capture
    exp_q.push_back({1'b0, 32'h100, 32'h0});
    enq(1'b0, 32'h100, 32'h0, 1'b0);
    check("ld_dren", dREN, 1);
    check("ld_daddr", daddr, 32'h100);
    check("ld_state", head_state, 2'd1);
    check("ld_count", count, 1);
    tick();
    dhit = 1'b1;
    tick();
    dhit = 1'b0;
    check("ld_dren_done", dREN, 0);
    check("ld_empty", empty, 1);
    dhit = 1'b1;
    tick();
    dhit = 1'b0;
    check("ld_dhit_empty", count, 0);

    // Fill and back-pressure
    exp_q.push_back({1'b1, 32'h200, 32'hA0});
    enq(1'b1, 32'h200, 32'hA0, 1'b0);
    check("fill_dwen", dWEN, 1);
    check("fill_daddr", daddr, 32'h200);
    exp_q.push_back({1'b1, 32'h204, 32'hA1});
    enq(1'b1, 32'h204, 32'hA1, 1'b1);
    check("fill_cnt1", count, 1);
    for (int i = 2; i < 5; i++) begin
      exp_q.push_back({1'b1, 32'h200 + 32'(4 * i), 32'hA0 + 32'(i)});
      enq(1'b1, 32'h200 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0);
    end
    check("fill_count4", count, 4);
    check("fill_full", full, 1);
    check("fill_iren", iREN, 0);
    check("fill_ovf_pre", overflow, 0);
    enq(1'b1, 32'h214, 32'hA5, 1'b0);
    check("ovf_set", overflow, 1);
    check("ovf_count", count, 4);
    check("ovf_gap_dwen", dWEN, 0);
    tick();
    check("gap_end_dwen", dWEN, 1);
    check("gap_end_daddr", daddr, 32'h204);
    exp_q.push_back({1'b1, 32'h218, 32'hA6});
    enq(1'b1, 32'h218, 32'hA6, 1'b1);
    check("full_swap_count", count, 4);
    check("full_swap_full", full, 1);
    dhit = 1'b1;
    repeat (4) tick();
    dhit = 1'b0;
    check("fill_drain_empty", empty, 1);
    check("fill_drain_dwen", dWEN, 0);
    check("fill_sb_left", 65'(exp_q.size()), 0);

    // Timeout and drop: 4 cycles presented, 1 gap, three windows then drop
    pat = 16'h3DEF;
    enq(1'b0, 32'h400, 32'h0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) tick();
      check($sformatf("to_dren_%0d", i), dREN, pat[i]);
      if (i == 4) check("to_gap_state", head_state, 2'd2);
      if (i == 14) check("to_terr_pre", timeout_err, 0);
    end
    check("to_terr", timeout_err, 1);
    check("to_empty", empty, 1);

    // Halt drain
    exp_q.push_back({1'b0, 32'h300, 32'h0});
    enq(1'b0, 32'h300, 32'h0, 1'b0);
    exp_q.push_back({1'b0, 32'h304, 32'h0});
    enq(1'b0, 32'h304, 32'h0, 1'b0);
    halt = 1'b1;
    #1;
    check("halt_iren", iREN, 0);
    check("halt_drained_pre", drained, 0);
    dhit = 1'b1;
    tick();
    check("halt_drained_mid", drained, 0);
    check("halt_count_mid", count, 1);
    tick();
    dhit = 1'b0;
    check("halt_drained", drained, 1);
    check("halt_empty", empty, 1);
    halt = 1'b0;
    #1;
    check("halt_sticky_iren", iREN, 0);
    check("sb_final", 65'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pend_req_unit.md
PEND_REQ_UNIT -- requirements
Module: pend_req_unit

Interface
REQ-001 The block SHALL have parameters: DEPTH, 4, pending-request queue entries (power of 2, >=2); ADDR_W, 32, address width; DATA_W, 32, store-data width; TIMEOUT, 16, cycles without dhit before retry; MAX_RETRY, 2, retries before the request is dropped.
REQ-002 The block SHALL have these ports:
- CLK  in  1  sole clock; all state updates on the rising edge.
- nRST  in  1  asynchronous active-low reset.
- ihit  in  1  instruction fetch completed this cycle.
- dhit  in  1  data access at queue head completed this cycle.
- dmemREN  in  1  decoded instruction is a load.
- dmemWEN  in  1  decoded instruction is a store.
- dmemaddr  in  ADDR_W  load/store address.
- dmemstore  in  DATA_W  store data.
- halt  in  1  drain request; stop fetching.
- iREN  out  1  instruction read enable.
- dREN  out  1  head request is a read.
- dWEN  out  1  head request is a write.
- daddr  out  ADDR_W  head address.
- dstore  out  DATA_W  head store data.
- count  out  $clog2(DEPTH)+1  occupied entries.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- drained  out  1  halt seen and queue empty.
- timeout_err  out  1  sticky; a request was dropped after MAX_RETRY retries.
- overflow  out  1  sticky; an enqueue arrived while full and was discarded.

Function
REQ-003 On a rising edge with ihit=1 and (dmemREN|dmemWEN)=1, the block SHALL enqueue {write, addr, data} at the tail, with write=dmemWEN (WEN wins if both are set).
REQ-004 dREN/dWEN/daddr/dstore SHALL reflect the head entry from the cycle after its capture (1-cycle latency), and dREN=dWEN=0 when empty or in the GAP state.
REQ-005 On dhit=1 with a non-empty queue in the REQ state, the head SHALL be popped on that edge; a dhit when empty or in GAP SHALL be ignored.
REQ-006 An enqueue and a pop on the same edge SHALL leave count unchanged, including when full.
REQ-007 An enqueue when full without a same-edge pop SHALL be discarded and SHALL set overflow.
REQ-008 iREN SHALL be 1 except when (full=1 and dhit=0) or halt has been seen; halt SHALL be latched sticky until reset.
REQ-009 drained SHALL equal halt_seen & empty.
REQ-010 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-011 The head FSM SHALL have three states:
- IDLE: queue empty. Moves to REQ when the queue is non-empty.
- REQ: outputs driven. The wait counter increments each cycle without dhit. dhit pops, clears the counters, and moves to REQ (if more entries remain) or IDLE. When the wait counter reaches TIMEOUT-1, the FSM moves to GAP.
- GAP: one cycle with dREN=dWEN=0. The retry counter increments. If the retry counter was already MAX_RETRY, the head is popped and timeout_err is set. The FSM then goes to REQ or IDLE.
REQ-012 The wait and retry counters SHALL reset to 0 on every pop.

Reset
REQ-013 While nRST=0, the block SHALL hold these values immediately, independent of CLK: pointers, count, counters, halt_seen, timeout_err and overflow at 0; state IDLE; dREN=dWEN=0; iREN=1; empty=1.
REQ-014 An assertion of nRST during an outstanding request SHALL discard all queued entries with no partial pop.

Structure
REQ-015 The head state enum (IDLE, REQ, GAP) and the queue entry struct SHALL be defined in cpu_types_pkg.
REQ-016 Queue storage and pointers SHALL live in one sub-module, req_fifo; the FSM, counters and flags SHALL live in pend_req_unit.

Verification
REQ-017 The bench SHALL cover these directed scenarios (all with DEPTH=4):
- Reset mid-request: nRST low with a request pending -> dREN=dWEN=0, count=0 and iREN=1 immediately.
- Single load: ihit, dmemREN, addr 0x100 -> next cycle dREN=1 and daddr=0x100; dhit 2 cycles later -> dREN=0 and empty=1.
- Fill and back-pressure: 4 stores with no dhit -> full=1, iREN=0. Fifth ihit with store -> discarded, overflow=1. Then dhit + ihit together -> count stays 4.
- Timeout and drop: TIMEOUT=4, MAX_RETRY=2, no dhit -> dREN low exactly one cycle after each 4-cycle window. After the third window, the head is dropped and timeout_err=1.
- Halt drain: halt with 2 entries pending, then 2 dhits -> iREN=0 at once; drained=1 the cycle after the second pop.
